// File: rtl/mem_load_unit.sv
// Multicycle load controller: checks alignment, issues a word read, waits with a
// timeout, then returns the sign/zero-extended lane with a one-cycle status pulse.
module mem_load_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddress,
  output logic        oReady,
  output logic        oMemRead,
  output logic [31:0] oMemAddr,
  input  logic [31:0] iMemData,
  input  logic        iMemValid,
  output logic [31:0] oData,
  output logic        oValid,
  output logic        oException,
  output logic        oTimeout
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       funct3_reg, funct3_next;
  logic [1:0]       align_reg, align_next;
  logic             mem_read_reg, mem_read_next;
  logic [31:0]      mem_addr_reg, mem_addr_next;
  logic [31:0]      data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             exc_reg, exc_next;
  logic             timeout_reg, timeout_next;

  logic [7:0]       lane [4];
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      extracted;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = iMemData[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[align_reg];
  assign half_sel = align_reg[1] ? iMemData[31:16] : iMemData[15:0];

  function automatic logic is_fault(input logic [2:0] f, input logic [1:0] a);
    case (f)
      F_LB, F_LBU: is_fault = 1'b0;
      F_LH, F_LHU: is_fault = a[0];
      F_LW:        is_fault = (a != 2'b00);
      default:     is_fault = 1'b1;
    endcase
  endfunction

  always_comb begin
    extracted = iMemData;
    case (funct3_reg)
      F_LB:    extracted = {{24{byte_sel[7]}}, byte_sel};
      F_LBU:   extracted = {24'd0, byte_sel};
      F_LH:    extracted = {{16{half_sel[15]}}, half_sel};
      F_LHU:   extracted = {16'd0, half_sel};
      default: extracted = iMemData;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    funct3_next   = funct3_reg;
    align_next    = align_reg;
    mem_read_next = mem_read_reg;
    mem_addr_next = mem_addr_reg;
    data_next     = data_reg;
    valid_next    = 1'b0;
    exc_next      = 1'b0;
    timeout_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (iStart) begin
          funct3_next = iFunct3;
          align_next  = iAddress[1:0];
          if (is_fault(iFunct3, iAddress[1:0])) begin
            state_next = S_DONE;
            exc_next   = 1'b1;
            data_next  = 32'd0;
          end else begin
            state_next    = S_WAIT;
            mem_read_next = 1'b1;
            mem_addr_next = {iAddress[31:2], 2'b00};
            cnt_next      = '0;
          end
        end
      end
      S_WAIT: begin
        // Data arriving on the limit edge wins over the timeout.
        if (iMemValid) begin
          data_next     = extracted;
          mem_read_next = 1'b0;
          valid_next    = 1'b1;
          state_next    = S_DONE;
        end else if (cnt_reg == CNT_LIMIT) begin
          data_next     = 32'd0;
          mem_read_next = 1'b0;
          timeout_next  = 1'b1;
          state_next    = S_DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      funct3_reg   <= 3'd0;
      align_reg    <= 2'd0;
      mem_read_reg <= 1'b0;
      mem_addr_reg <= 32'd0;
      data_reg     <= 32'd0;
      valid_reg    <= 1'b0;
      exc_reg      <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      funct3_reg   <= funct3_next;
      align_reg    <= align_next;
      mem_read_reg <= mem_read_next;
      mem_addr_reg <= mem_addr_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      exc_reg      <= exc_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign oReady     = (state_reg == S_IDLE);
  assign oMemRead   = mem_read_reg;
  assign oMemAddr   = mem_addr_reg;
  assign oData      = data_reg;
  assign oValid     = valid_reg;
  assign oException = exc_reg;
  assign oTimeout   = timeout_reg;

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed and randomized loads against an arithmetic reference model of the
// load unit (TIMEOUT_CYCLES=4), covering lanes, faults, timeout, busy and reset.
module tb_mem_load_unit;
  localparam int TMO = 4;

  logic        iCLK = 1'b0;
  logic        iRST, iStart, iMemValid;
  logic [2:0]  iFunct3;
  logic [31:0] iAddress, iMemData;
  logic        oReady, oMemRead, oValid, oException, oTimeout;
  logic [31:0] oMemAddr, oData;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_data = 32'd0;

  mem_load_unit #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iFunct3(iFunct3),
    .iAddress(iAddress), .oReady(oReady), .oMemRead(oMemRead),
    .oMemAddr(oMemAddr), .iMemData(iMemData), .iMemValid(iMemValid),
    .oData(oData), .oValid(oValid), .oException(oException), .oTimeout(oTimeout)
  );

  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: returns {fault, result} from the load rules using plain arithmetic.
  function automatic logic [32:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] w);
    longint unsigned off = a % 4;
    longint unsigned b   = (longint'(w) >> (8 * off)) % 256;
    longint unsigned h   = (longint'(w) >> (16 * (off / 2))) % 65536;
    case (f)
      3'd0: return {1'b0, (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b)};
      3'd4: return {1'b0, 32'(b)};
      3'd1: return (off % 2 != 0) ? 33'h1_0000_0000
                                  : {1'b0, (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h)};
      3'd5: return (off % 2 != 0) ? 33'h1_0000_0000 : {1'b0, 32'(h)};
      3'd2: return (off != 0) ? 33'h1_0000_0000 : {1'b0, w};
      default: return 33'h1_0000_0000;
    endcase
  endfunction

  // One load: memory answers after 'delay' WAIT cycles (delay >= TMO means never).
  task automatic do_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w,
                         input int delay, input bit busy);
    logic [32:0] m = model(f, a, w);
    logic [31:0] exp_addr = a & 32'hFFFF_FFFC;
    bit drove;
    chk("ready_before", {31'd0, oReady}, 32'd1);
    iStart = 1'b1; iFunct3 = f; iAddress = a;
    tick();
    iStart = 1'b0;
    if (m[32]) begin
      chk("exc_pulse", {31'd0, oException}, 32'd1);
      chk("exc_memread", {31'd0, oMemRead}, 32'd0);
      chk("exc_data", oData, 32'd0);
      last_data = 32'd0;
      tick();
      chk("exc_ready_after", {31'd0, oReady}, 32'd1);
      chk("exc_pulse_off", {31'd0, oException}, 32'd0);
      $display("[TB] load f3=%0d addr=%h -> exception", f, a);
      return;
    end
    chk("memread_on", {31'd0, oMemRead}, 32'd1);
    chk("memaddr", oMemAddr, exp_addr);
    for (int cyc = 0; cyc <= TMO; cyc++) begin
      drove = (cyc == delay);
      iMemValid = drove;
      iMemData  = drove ? w : $urandom;
      if (busy) begin
        iStart = 1'b1; iFunct3 = 3'd2; iAddress = 32'h200;
      end
      tick();
      iMemValid = 1'b0;
      iStart = 1'b0;
      if (drove) begin
        chk("valid_pulse", {31'd0, oValid}, 32'd1);
        chk("result", oData, m[31:0]);
        chk("timeout_quiet", {31'd0, oTimeout}, 32'd0);
        chk("memread_off", {31'd0, oMemRead}, 32'd0);
        last_data = m[31:0];
        break;
      end else if (cyc + 1 == TMO) begin
        chk("timeout_pulse", {31'd0, oTimeout}, 32'd1);
        chk("timeout_data", oData, 32'd0);
        chk("timeout_novalid", {31'd0, oValid}, 32'd0);
        chk("timeout_memread", {31'd0, oMemRead}, 32'd0);
        last_data = 32'd0;
        break;
      end else begin
        chk("wait_memread", {31'd0, oMemRead}, 32'd1);
        chk("wait_addr", oMemAddr, exp_addr);
        chk("wait_novalid", {31'd0, oValid}, 32'd0);
        chk("wait_busy", {31'd0, oReady}, 32'd0);
      end
    end
    tick();
    chk("pulse_one_cycle", {31'd0, oValid | oTimeout}, 32'd0);
    chk("ready_after", {31'd0, oReady}, 32'd1);
    chk("data_held", oData, last_data);
    $display("[TB] load f3=%0d addr=%h word=%h delay=%0d -> data=%h", f, a, w, delay, oData);
  endtask

  initial begin
    iRST = 1'b1; iStart = 1'b0; iFunct3 = 3'd0; iAddress = 32'd0;
    iMemData = 32'd0; iMemValid = 1'b0;
    tick(); tick();
    iRST = 1'b0;
    chk("rst_ready", {31'd0, oReady}, 32'd1);
    chk("rst_memread", {31'd0, oMemRead}, 32'd0);
    chk("rst_memaddr", oMemAddr, 32'd0);
    chk("rst_data", oData, 32'd0);
    chk("rst_pulses", {29'd0, oValid, oException, oTimeout}, 32'd0);

    // IDLE ignores iMemValid
    iMemValid = 1'b1; iMemData = 32'hDEADBEEF;
    tick();
    iMemValid = 1'b0;
    chk("idle_ignore_valid", {31'd0, oValid}, 32'd0);
    chk("idle_ignore_data", oData, 32'd0);

    // Lane extraction
    do_load(3'd0, 32'h100, 32'h8765F0A1, 0, 1'b0);
    chk("lb", oData, 32'hFFFFFFA1);
    do_load(3'd4, 32'h101, 32'h8765F0A1, 0, 1'b0);
    chk("lbu", oData, 32'h000000F0);
    do_load(3'd1, 32'h102, 32'h8765F0A1, 0, 1'b0);
    chk("lh", oData, 32'hFFFF8765);
    do_load(3'd5, 32'h102, 32'h8765F0A1, 0, 1'b0);
    chk("lhu", oData, 32'h00008765);
    do_load(3'd2, 32'h100, 32'h8765F0A1, 0, 1'b0);
    chk("lw", oData, 32'h8765F0A1);

    // Faults
    do_load(3'd2, 32'h1002, 32'h0, 0, 1'b0);
    do_load(3'd3, 32'h1000, 32'h0, 0, 1'b0);
    do_load(3'd1, 32'h1001, 32'h0, 0, 1'b0);

    // Timeout, simultaneity, busy, address wrap
    do_load(3'd2, 32'h300, 32'h11111111, TMO + 2, 1'b0);
    do_load(3'd2, 32'h400, 32'h12345678, TMO - 1, 1'b0);
    chk("simultaneous", oData, 32'h12345678);
    do_load(3'd2, 32'h500, 32'hCAFEF00D, 2, 1'b1);
    chk("busy_first_only", oData, 32'hCAFEF00D);
    do_load(3'd0, 32'hFFFFFFFF, 32'h7F000000, 1, 1'b0);

    // Randomized loads
    for (int i = 0; i < 40; i++)
      do_load(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, TMO + 1),
              1'($urandom_range(0, 1)));

    // Reset mid-WAIT
    do_load(3'd2, 32'h600, 32'hA5A5A5A5, 0, 1'b0);
    iStart = 1'b1; iFunct3 = 3'd2; iAddress = 32'h700;
    tick();
    iStart = 1'b0;
    tick();
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    chk("rstwait_memread", {31'd0, oMemRead}, 32'd0);
    chk("rstwait_ready", {31'd0, oReady}, 32'd1);
    chk("rstwait_data", oData, 32'd0);
    chk("rstwait_pulses", {29'd0, oValid, oException, oTimeout}, 32'd0);
    tick();
    iMemValid = 1'b1; iMemData = 32'h55AA55AA;
    tick();
    iMemValid = 1'b0;
    chk("late_valid_ignored", {31'd0, oValid}, 32'd0);
    chk("late_data_ignored", oData, 32'd0);
    $display("[TB] reset mid-wait -> memread=%0d ready=%0d data=%h", oMemRead, oReady, oData);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
